// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the UART bridge: arbiter FSM states, grant source
// encodings and the default frame width.
package uart_bridge_pkg;

   localparam int unsigned DW_DEFAULT = 56;

   localparam logic SRC_REQ = 1'b0;
   localparam logic SRC_RES = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_READ      = 3'd1,
      ST_CAPTURE   = 3'd2,
      ST_LAUNCH    = 3'd3,
      ST_WAIT_DONE = 3'd4
   } arb_state_e;

   function automatic int unsigned sat_inc(input int unsigned val, input int unsigned max_val);
      return (val >= max_val) ? max_val : val + 1;
   endfunction

endpackage

// File: rtl/arb_launch_timer.sv
// Launch watchdog: counts enabled cycles since the last clear and flags the cycle
// that is the START_TO-th enabled cycle.
module arb_launch_timer #(
   parameter int unsigned START_TO = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int unsigned TW = $clog2(START_TO + 1);

   logic [TW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != TW'(START_TO))) begin
         cnt_d = cnt_q + TW'(1);
      end
   end

   // The current cycle counts toward the limit, so the flag fires when START_TO-1 have elapsed.
   assign tc = en && (cnt_q == TW'(START_TO - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates the request and response frame FIFOs onto the single UART transmitter:
// responses first, with a cap on consecutive response grants while a request waits.
module uart_tx_arbiter
   import uart_bridge_pkg::*;
#(
   parameter int unsigned DW         = DW_DEFAULT,
   parameter int unsigned MAX_CONSEC = 4,
   parameter int unsigned START_TO   = 16
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          tx_en,
   input  logic          req_vld,
   input  logic [DW-1:0] req_data,
   input  logic          res_vld,
   input  logic [DW-1:0] res_data,
   input  logic          tx_busy,
   output logic          req_ren,
   output logic          res_ren,
   output logic [DW-1:0] tx_data,
   output logic          tx_vld,
   output logic          tx_src,
   output logic          launch_err
);

   localparam int unsigned CW = $clog2(MAX_CONSEC + 1);

   arb_state_e    state_q, state_d;
   logic [CW-1:0] consec_q, consec_d;
   logic          req_ren_q, req_ren_d;
   logic          res_ren_q, res_ren_d;
   logic [DW-1:0] tx_data_q, tx_data_d;
   logic          tx_vld_q, tx_vld_d;
   logic          tx_src_q, tx_src_d;
   logic          launch_err_q, launch_err_d;
   logic          timer_clr, timer_tc;

   assign timer_clr = !tx_en || (state_q != ST_LAUNCH);

   arb_launch_timer #(
      .START_TO (START_TO)
   ) u_timer (
      .clk (CLK),
      .rst (RST),
      .clr (timer_clr),
      .en  (state_q == ST_LAUNCH),
      .tc  (timer_tc)
   );

   always_comb begin
      state_d      = state_q;
      consec_d     = consec_q;
      req_ren_d    = 1'b0;
      res_ren_d    = 1'b0;
      tx_data_d    = tx_data_q;
      tx_vld_d     = tx_vld_q;
      tx_src_d     = tx_src_q;
      launch_err_d = 1'b0;
      if (!tx_en) begin
         // Abort: any frame already read is dropped; tx_data and tx_src keep their values.
         state_d  = ST_IDLE;
         tx_vld_d = 1'b0;
         consec_d = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (!tx_busy) begin
                  if (res_vld && !(req_vld && (consec_q == CW'(MAX_CONSEC)))) begin
                     tx_src_d  = SRC_RES;
                     res_ren_d = 1'b1;
                     consec_d  = CW'(sat_inc(32'(consec_q), MAX_CONSEC));
                     state_d   = ST_READ;
                  end else if (req_vld) begin
                     tx_src_d  = SRC_REQ;
                     req_ren_d = 1'b1;
                     consec_d  = '0;
                     state_d   = ST_READ;
                  end
               end
            end
            ST_READ: state_d = ST_CAPTURE;
            ST_CAPTURE: begin
               tx_data_d = (tx_src_q == SRC_RES) ? res_data : req_data;
               tx_vld_d  = 1'b1;
               state_d   = ST_LAUNCH;
            end
            ST_LAUNCH: begin
               if (tx_busy) begin
                  tx_vld_d = 1'b0;
                  state_d  = ST_WAIT_DONE;
               end else if (timer_tc) begin
                  tx_vld_d     = 1'b0;
                  launch_err_d = 1'b1;
                  state_d      = ST_IDLE;
               end
            end
            ST_WAIT_DONE: begin
               if (!tx_busy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= ST_IDLE;
         consec_q     <= '0;
         req_ren_q    <= 1'b0;
         res_ren_q    <= 1'b0;
         tx_data_q    <= '0;
         tx_vld_q     <= 1'b0;
         tx_src_q     <= 1'b0;
         launch_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         consec_q     <= consec_d;
         req_ren_q    <= req_ren_d;
         res_ren_q    <= res_ren_d;
         tx_data_q    <= tx_data_d;
         tx_vld_q     <= tx_vld_d;
         tx_src_q     <= tx_src_d;
         launch_err_q <= launch_err_d;
      end
   end

   assign req_ren    = req_ren_q;
   assign res_ren    = res_ren_q;
   assign tx_data    = tx_data_q;
   assign tx_vld     = tx_vld_q;
   assign tx_src     = tx_src_q;
   assign launch_err = launch_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: FIFO and UART models, a scoreboard fed by a grant-order
// model, directed latency/abort/reset scenarios and randomized traffic.
module tb_uart_tx_arbiter;

   localparam int DW         = 56;
   localparam int MAX_CONSEC = 4;
   localparam int START_TO   = 16;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          tx_en = 1'b0;
   logic          req_vld = 1'b0;
   logic [DW-1:0] req_data = '0;
   logic          res_vld = 1'b0;
   logic [DW-1:0] res_data = '0;
   logic          tx_busy;
   logic          req_ren, res_ren, tx_vld, tx_src, launch_err;
   logic [DW-1:0] tx_data;

   typedef struct packed {
      logic          src;
      logic [DW-1:0] data;
   } frame_t;

   frame_t        sb[$];
   logic [DW-1:0] req_fifo[$], res_fifo[$], mod_req[$], mod_res[$];
   int            n_vec = 0;
   int            n_err = 0;
   logic          auto_uart = 1'b0, allow_drop = 1'b0, force_drop = 1'b0;
   logic          uart_busy = 1'b0, dir_busy = 1'b0, uart_active = 1'b0;
   logic          vld_prev = 1'b0;

   assign tx_busy = uart_busy | dir_busy;

   always #5 CLK = ~CLK;

   uart_tx_arbiter #(
      .DW         (DW),
      .MAX_CONSEC (MAX_CONSEC),
      .START_TO   (START_TO)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .tx_en      (tx_en),
      .req_vld    (req_vld),
      .req_data   (req_data),
      .res_vld    (res_vld),
      .res_data   (res_data),
      .tx_busy    (tx_busy),
      .req_ren    (req_ren),
      .res_ren    (res_ren),
      .tx_data    (tx_data),
      .tx_vld     (tx_vld),
      .tx_src     (tx_src),
      .launch_err (launch_err)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge CLK);
   endtask

   // FIFO model: read data appears the cycle after the strobe; non-empty flag is registered.
   always @(posedge CLK) begin
      if (req_ren && req_fifo.size() != 0) req_data <= req_fifo.pop_front();
      if (res_ren && res_fifo.size() != 0) res_data <= res_fifo.pop_front();
      req_vld <= (req_fifo.size() != 0);
      res_vld <= (res_fifo.size() != 0);
   end

   task automatic push(input logic src, input logic [DW-1:0] d);
      if (src) begin
         res_fifo.push_back(d);
         mod_res.push_back(d);
      end else begin
         req_fifo.push_back(d);
         mod_req.push_back(d);
      end
   endtask

   function automatic logic [DW-1:0] rnd_frame();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[DW-1:0];
   endfunction

   // Grant order from queue occupancy: responses win unless a request has waited through
   // MAX_CONSEC back-to-back response grants.
   task automatic predict(input int consec0);
      int c = consec0;
      while (mod_res.size() != 0 || mod_req.size() != 0) begin
         if (mod_res.size() != 0 && !(mod_req.size() != 0 && c == MAX_CONSEC)) begin
            sb.push_back('{src: 1'b1, data: mod_res.pop_front()});
            c = (c == MAX_CONSEC) ? MAX_CONSEC : c + 1;
         end else begin
            sb.push_back('{src: 1'b0, data: mod_req.pop_front()});
            c = 0;
         end
      end
   endtask

   // Monitor: each new frame offered to the UART is compared with the scoreboard head.
   always @(negedge CLK) begin
      frame_t e;
      if (tx_vld && !vld_prev) begin
         if (sb.size() == 0) begin
            chk("unexpected_frame", {63'd0, tx_vld}, 64'd0);
         end else begin
            e = sb.pop_front();
            chk("frame_src", {63'd0, tx_src}, {63'd0, e.src});
            chk("frame_data", {8'd0, tx_data}, {8'd0, e.data});
         end
      end
      vld_prev = tx_vld;
      if (req_ren || res_ren) chk("ren_exclusive", {63'd0, req_ren & res_ren}, 64'd0);
   end

   // UART model: accepts after a random delay, or ignores the frame to provoke a timeout.
   initial begin
      int   d, b;
      logic drop;
      forever begin
         @(negedge CLK);
         if (auto_uart && tx_vld) begin
            uart_active = 1'b1;
            drop = force_drop || (allow_drop && ($urandom_range(0, 7) == 0));
            if (drop) begin
               force_drop = 1'b0;
               for (int k = 1; k < START_TO; k++) begin
                  @(negedge CLK);
                  chk("launch_hold", {63'd0, tx_vld}, 64'd1);
               end
               @(negedge CLK);
               chk("launch_err", {63'd0, launch_err}, 64'd1);
               chk("timeout_vld", {63'd0, tx_vld}, 64'd0);
               @(negedge CLK);
               chk("launch_err_pulse", {63'd0, launch_err}, 64'd0);
            end else begin
               d = $urandom_range(0, 4);
               repeat (d) @(negedge CLK);
               uart_busy = 1'b1;
               b = $urandom_range(1, 4);
               @(negedge CLK);
               chk("vld_drop_on_busy", {63'd0, tx_vld}, 64'd0);
               repeat (b - 1) @(negedge CLK);
               uart_busy = 1'b0;
            end
            uart_active = 1'b0;
         end
      end
   end

   task automatic begin_phase();
      tx_en = 1'b0;
      step();
   endtask

   task automatic start_phase();
      step();
      step();
      tx_en = 1'b1;
   endtask

   task automatic wait_drain();
      bit done = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         step();
         if (sb.size() == 0 && !uart_active && !tx_vld &&
             req_fifo.size() == 0 && res_fifo.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      chk("drain", {63'd0, done}, 64'd1);
      if (!done) begin
         sb.delete();
         req_fifo.delete();
         res_fifo.delete();
      end
      repeat (3) step();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req_ren"}, {63'd0, req_ren}, 64'd0);
      chk({tag, "_res_ren"}, {63'd0, res_ren}, 64'd0);
      chk({tag, "_tx_vld"}, {63'd0, tx_vld}, 64'd0);
      chk({tag, "_tx_src"}, {63'd0, tx_src}, 64'd0);
      chk({tag, "_launch_err"}, {63'd0, launch_err}, 64'd0);
      chk({tag, "_tx_data"}, {8'd0, tx_data}, 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int nres, nreq;

      step();
      chk_all_zero("reset");
      step();
      RST = 1'b0;

      // Request-only latency: vld at N, ren at N+1, tx_vld at N+3, busy at N+5.
      begin_phase();
      tx_en = 1'b1;
      step();
      step();
      push(1'b0, 56'h00_1234_5678_9ABC);
      predict(0);
      step();
      chk("ro_no_ren_N", {63'd0, req_ren}, 64'd0);
      step();
      chk("ro_req_ren", {63'd0, req_ren}, 64'd1);
      chk("ro_res_ren", {63'd0, res_ren}, 64'd0);
      step();
      chk("ro_ren_one_cycle", {63'd0, req_ren}, 64'd0);
      chk("ro_vld_early", {63'd0, tx_vld}, 64'd0);
      step();
      chk("ro_vld", {63'd0, tx_vld}, 64'd1);
      chk("ro_data", {8'd0, tx_data}, 64'h0000_1234_5678_9ABC);
      chk("ro_src", {63'd0, tx_src}, 64'd0);
      step();
      chk("ro_vld_hold", {63'd0, tx_vld}, 64'd1);
      step();
      chk("ro_vld_hold2", {63'd0, tx_vld}, 64'd1);
      dir_busy = 1'b1;
      step();
      chk("ro_vld_drop", {63'd0, tx_vld}, 64'd0);
      step();
      dir_busy = 1'b0;
      repeat (2) step();

      // Busy gate: no grant while tx_busy is high in IDLE.
      begin_phase();
      dir_busy = 1'b1;
      push(1'b1, rnd_frame());
      predict(0);
      start_phase();
      repeat (6) begin
         step();
         chk("gate_no_ren", {63'd0, req_ren | res_ren}, 64'd0);
      end
      dir_busy = 1'b0;
      step();
      chk("gate_res_ren", {63'd0, res_ren}, 64'd1);
      auto_uart = 1'b1;
      wait_drain();

      // Launch timeout on the first frame, normal service for the next.
      begin_phase();
      push(1'b0, rnd_frame());
      push(1'b1, rnd_frame());
      predict(0);
      force_drop = 1'b1;
      start_phase();
      wait_drain();

      // Starvation cap, then abort during CAPTURE of the request frame.
      begin_phase();
      for (int i = 0; i < 5; i++) push(1'b1, rnd_frame());
      push(1'b0, rnd_frame());
      push(1'b0, rnd_frame());
      for (int i = 0; i < 4; i++) sb.push_back('{src: 1'b1, data: mod_res.pop_front()});
      void'(mod_req.pop_front());
      predict(0);
      start_phase();
      ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
         step();
         if (req_ren) begin
            ok = 1'b1;
            break;
         end
      end
      chk("starve_req_ren", {63'd0, ok}, 64'd1);
      chk("starve_res_count", 64'(sb.size()), 64'd2);
      step();
      tx_en = 1'b0;
      step();
      chk("abort_vld", {63'd0, tx_vld}, 64'd0);
      chk("abort_ren", {63'd0, req_ren | res_ren}, 64'd0);
      tx_en = 1'b1;
      step();
      chk("abort_res_first", {63'd0, res_ren}, 64'd1);
      chk("abort_no_req", {63'd0, req_ren}, 64'd0);
      wait_drain();

      // Randomized bursts with occasional ignored launches.
      allow_drop = 1'b1;
      repeat (6) begin
         begin_phase();
         nres = $urandom_range(0, 6);
         nreq = $urandom_range(0, 6);
         while (nres > 0 || nreq > 0) begin
            if (nres > 0 && (nreq == 0 || $urandom_range(0, 1) == 1)) begin
               push(1'b1, rnd_frame());
               nres--;
            end else begin
               push(1'b0, rnd_frame());
               nreq--;
            end
         end
         predict(0);
         start_phase();
         wait_drain();
      end
      allow_drop = 1'b0;

      // Asynchronous reset while a response frame is in LAUNCH.
      auto_uart = 1'b0;
      begin_phase();
      push(1'b1, rnd_frame());
      predict(0);
      start_phase();
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (tx_vld) begin
            ok = 1'b1;
            break;
         end
      end
      chk("rst_reach_launch", {63'd0, ok}, 64'd1);
      step();
      #2;
      RST = 1'b1;
      #1;
      chk_all_zero("rst_async");
      step();
      RST = 1'b0;
      step();
      chk("rst_release_ren", {63'd0, req_ren | res_ren}, 64'd0);
      chk("rst_release_vld", {63'd0, tx_vld}, 64'd0);
      auto_uart = 1'b1;
      begin_phase();
      push(1'b0, rnd_frame());
      predict(0);
      start_phase();
      wait_drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
